// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: clock-enable pixel divider, h/v counters, and registered
// sync/blanking/strobe outputs decoded from the next counter state.
module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_VIDEO    = 640,
  parameter int H_FRONTP   = 16,
  parameter int H_PULSE    = 96,
  parameter int H_BACKP    = 48,
  parameter int V_VIDEO    = 480,
  parameter int V_FRONTP   = 10,
  parameter int V_PULSE    = 2,
  parameter int V_BACKP    = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CW         = 11
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL  = H_VIDEO + H_FRONTP + H_PULSE + H_BACKP;
  localparam int V_TOTAL  = V_VIDEO + V_FRONTP + V_PULSE + V_BACKP;
  localparam int HS_START = H_VIDEO + H_FRONTP;
  localparam int HS_END   = HS_START + H_PULSE;
  localparam int VS_START = V_VIDEO + V_FRONTP;
  localparam int VS_END   = VS_START + V_PULSE;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_VIDEO == 0 || H_FRONTP == 0 || H_PULSE == 0 || H_BACKP == 0 ||
      V_VIDEO == 0 || V_FRONTP == 0 || V_PULSE == 0 || V_BACKP == 0) begin : g_bad_timing
    $error("vga_timing_gen: timing parameters must be non-zero");
  end
  if (H_TOTAL >= 2**CW || V_TOTAL >= 2**CW) begin : g_bad_width
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          tick_d;
  logic          pix_tick_q, hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;
  logic          hs_act_d, vs_act_d, video_d;

  always_comb begin
    tick_d = (div_q == DW'(CLK_DIV - 1));
    div_d  = tick_d ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    if (tick_d) begin
      if (h_q == CW'(H_TOTAL - 1)) begin
        h_d = '0;
        if (v_q == CW'(V_TOTAL - 1)) v_d = '0;
        else                         v_d = v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Decode from the next counter state so outputs land on the same edge as the counters.
  always_comb begin
    hs_act_d = (h_d >= CW'(HS_START)) && (h_d < CW'(HS_END));
    vs_act_d = (v_d >= CW'(VS_START)) && (v_d < CW'(VS_END));
    video_d  = (h_d < CW'(H_VIDEO)) && (v_d < CW'(V_VIDEO));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      pix_tick_q    <= 1'b0;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pix_tick_q    <= tick_d;
      hsync_q       <= hs_act_d ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_q       <= vs_act_d ? V_SYNC_POL : ~V_SYNC_POL;
      video_on_q    <= video_d;
      // Strobes need a tick, so the (0,0) position left by reset never pulses.
      line_start_q  <= tick_d && (h_d == '0);
      frame_start_q <= tick_d && (h_d == '0) && (v_d == '0);
    end
  end

  assign pix_tick    = pix_tick_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign x           = h_q;
  assign y           = v_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
